// File: rtl/sync_ptr_gray_if.sv
// Pointer bus for sync_ptr_gray: the foreign-domain Gray pointer going in,
// and the synchronized pointer, binary view, step size and error status coming out.
interface sync_ptr_gray_if #(
    parameter int unsigned ASIZE = 4,
    parameter int unsigned ECW   = 8
) ();
    logic [ASIZE:0] rptr;
    logic [ASIZE:0] wq_rptr;
    logic [ASIZE:0] wq_rptr_bin;
    logic           wq_rptr_upd;
    logic [ASIZE:0] wq_rptr_delta;
    logic           err_pulse;
    logic           err_sticky;
    logic [ECW-1:0] err_cnt;

    modport master (
        output rptr,
        input  wq_rptr, wq_rptr_bin, wq_rptr_upd, wq_rptr_delta,
        input  err_pulse, err_sticky, err_cnt
    );

    modport slave (
        input  rptr,
        output wq_rptr, wq_rptr_bin, wq_rptr_upd, wq_rptr_delta,
        output err_pulse, err_sticky, err_cnt
    );
endinterface

// File: rtl/sync_ptr_gray.sv
// Gray pointer synchronizer into wclk with registered binary view, step delta,
// update pulse and optional Gray-code checker (enabled by SYNC_PTR_GRAY_CHECK_EN).
module sync_ptr_gray #(
    parameter int unsigned ASIZE  = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned ECW    = 8
) (
    input  logic            wclk,
    input  logic            wrst,
    sync_ptr_gray_if.slave  bus
);
    logic [ASIZE:0] sync_q [STAGES];
    logic [ASIZE:0] bin_d, bin_q;
    logic [ASIZE:0] delta_d, delta_q;
    logic           upd_d, upd_q;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            for (int unsigned i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.rptr;
            for (int unsigned i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // bin_q doubles as the previous-value register: it always holds last cycle's output.
    always_comb begin
        bin_d = '0;
        for (int unsigned i = 0; i <= ASIZE; i++) bin_d[i] = ^(sync_q[STAGES-1] >> i);
        delta_d = bin_d - bin_q;
        upd_d   = (bin_d != bin_q);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            bin_q   <= '0;
            delta_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            delta_q <= delta_d;
            upd_q   <= upd_d;
        end
    end

    assign bus.wq_rptr       = sync_q[STAGES-1];
    assign bus.wq_rptr_bin   = bin_q;
    assign bus.wq_rptr_delta = delta_q;
    assign bus.wq_rptr_upd   = upd_q;

`ifdef SYNC_PTR_GRAY_CHECK_EN
    localparam int unsigned   AW       = $clog2(STAGES + 2);
    localparam logic [AW-1:0] ARM_DONE = AW'(STAGES + 1);

    logic [AW-1:0]  arm_q, arm_d;
    logic           err_pulse_q, err_sticky_q;
    logic [ECW-1:0] err_cnt_q, err_cnt_d;
    logic [ASIZE:0] gray_prev, gray_diff;
    logic           viol;

    // Previous Gray value is recovered from bin_q instead of a separate register.
    always_comb begin
        gray_prev = bin_q ^ (bin_q >> 1);
        gray_diff = sync_q[STAGES-1] ^ gray_prev;
        viol      = (arm_q == ARM_DONE) &&
                    ((gray_diff & (gray_diff - (ASIZE+1)'(1))) != '0);
        arm_d     = (arm_q == ARM_DONE) ? arm_q : arm_q + AW'(1);
        err_cnt_d = err_cnt_q;
        if (viol && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ECW'(1);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            arm_q        <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            arm_q        <= arm_d;
            err_pulse_q  <= viol;
            err_sticky_q <= err_sticky_q | viol;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_cnt    = err_cnt_q;
`else
    assign bus.err_pulse  = 1'b0;
    assign bus.err_sticky = 1'b0;
    assign bus.err_cnt    = '0;
`endif
endmodule

// File: tb/tb_sync_ptr_gray.sv
// Scoreboard bench for sync_ptr_gray (ASIZE=4, STAGES=2) with ECW=8 and ECW=2 instances
// fed the same pointer; error expectations follow SYNC_PTR_GRAY_CHECK_EN.
module tb_sync_ptr_gray;
`ifdef SYNC_PTR_GRAY_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic wclk = 1'b0;
    logic wrst = 1'b1;
    always #5 wclk = ~wclk;

    sync_ptr_gray_if #(.ASIZE(4), .ECW(8)) if8 ();
    sync_ptr_gray_if #(.ASIZE(4), .ECW(2)) if2 ();

    sync_ptr_gray #(.ASIZE(4), .STAGES(2), .ECW(8)) u_dut (
        .wclk (wclk), .wrst (wrst), .bus (if8.slave));
    sync_ptr_gray #(.ASIZE(4), .STAGES(2), .ECW(2)) u_dut_e2 (
        .wclk (wclk), .wrst (wrst), .bus (if2.slave));

    typedef struct {
        logic [4:0] wq, bin, delta;
        logic       upd, ep, es, es2;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t exp_q [$];
    int   n_chk = 0;
    int   n_err = 0;

    // reference state: last sample, synchronized Gray (current and previous), binary, arm, errors
    logic [4:0] m_s1 = '0, m_wq = '0, m_wqp = '0, m_bin = '0;
    int         m_arm = 0;
    logic       m_es = 1'b0;
    int         m_cnt = 0, m_cnt2 = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] to_gray(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic model_step(input logic rst, input logic [4:0] r, output exp_t e);
        logic [4:0] nbin;
        logic       viol;
        if (rst) begin
            m_s1 = '0; m_wq = '0; m_wqp = '0; m_bin = '0;
            m_arm = 0; m_es = 1'b0; m_cnt = 0; m_cnt2 = 0;
            e = '{wq:'0, bin:'0, delta:'0, upd:1'b0, ep:1'b0, es:1'b0, es2:1'b0,
                  cnt:'0, cnt2:'0};
        end else begin
            nbin = g2b(m_wq);
            viol = CHECK && (m_arm >= 3) && ($countones(m_wq ^ m_wqp) > 1);
            if (viol) begin
                m_es = 1'b1;
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            e.wq    = m_s1;
            e.bin   = nbin;
            e.delta = nbin - m_bin;
            e.upd   = (nbin != m_bin);
            e.ep    = viol;
            e.es    = m_es;
            e.es2   = m_es;
            e.cnt   = m_cnt[7:0];
            e.cnt2  = m_cnt2[1:0];
            if (m_arm < 3) m_arm++;
            m_wqp = m_wq;
            m_wq  = m_s1;
            m_s1  = r;
            m_bin = nbin;
        end
    endtask

    task automatic step(input logic rst, input logic [4:0] r);
        exp_t e;
        wrst     = rst;
        if8.rptr = r;
        if2.rptr = r;
        model_step(rst, r, e);
        exp_q.push_back(e);
        @(posedge wclk);
        #1;
        if (exp_q.size() == 0) begin
            chk_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk_eq("wq_rptr",     {27'd0, if8.wq_rptr},       {27'd0, e.wq});
            chk_eq("wq_rptr_bin", {27'd0, if8.wq_rptr_bin},   {27'd0, e.bin});
            chk_eq("delta",       {27'd0, if8.wq_rptr_delta}, {27'd0, e.delta});
            chk_eq("upd",         {31'd0, if8.wq_rptr_upd},   {31'd0, e.upd});
            chk_eq("err_pulse",   {31'd0, if8.err_pulse},     {31'd0, e.ep});
            chk_eq("err_sticky",  {31'd0, if8.err_sticky},    {31'd0, e.es});
            chk_eq("err_cnt",     {24'd0, if8.err_cnt},       {24'd0, e.cnt});
            chk_eq("e2_bin",      {27'd0, if2.wq_rptr_bin},   {27'd0, e.bin});
            chk_eq("e2_err_pulse",{31'd0, if2.err_pulse},     {31'd0, e.ep});
            chk_eq("e2_sticky",   {31'd0, if2.err_sticky},    {31'd0, e.es2});
            chk_eq("e2_err_cnt",  {30'd0, if2.err_cnt},       {30'd0, e.cnt2});
        end
    endtask

    initial begin
        // reset with a non-zero pointer present, then first transition 0 -> 1F
        repeat (3) step(1'b1, 5'h1F);
        repeat (5) step(1'b0, 5'h1F);
        chk_eq("post_reset_bin_15", {27'd0, if8.wq_rptr_bin}, 32'h15);
        // Gray walk continuing from binary 21 through the 31 -> 0 wrap
        for (int b = 22; b < 22 + 42; b++) step(1'b0, to_gray(b));
        // reset mid-walk discards in-flight samples
        step(1'b1, to_gray(64));
        step(1'b1, to_gray(65));
        repeat (10) step(1'b0, 5'h0C);
        chk_eq("hold_upd_0",   {31'd0, if8.wq_rptr_upd},   32'd0);
        chk_eq("hold_delta_0", {27'd0, if8.wq_rptr_delta}, 32'd0);
        // downward walk 8 -> 0 gives delta 1F each step
        for (int b = 7; b >= 0; b--) step(1'b0, to_gray(b));
        repeat (3) step(1'b0, 5'h00);
        step(1'b0, 5'h03);
        repeat (5) step(1'b0, 5'h03);
        // saturation: five spaced violations, then back-to-back ones
        step(1'b1, 5'h00);
        step(1'b1, 5'h00);
        repeat (5) step(1'b0, 5'h00);
        for (int k = 0; k < 5; k++) begin
            repeat (3) step(1'b0, (k % 2 == 0) ? 5'h03 : 5'h00);
        end
        for (int k = 0; k < 4; k++) step(1'b0, (k % 2 == 0) ? 5'h00 : 5'h03);
        repeat (3) step(1'b0, 5'h03);
        repeat (2) step(1'b1, 5'h1A);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sync_ptr_gray.md
SYNC_PTR_GRAY -- requirements
Module: sync_ptr_gray

Interface
REQ-001 Parameter ASIZE, default 4: pointer is ASIZE+1 bits (address plus wrap bit).
REQ-002 Parameter STAGES, default 2: synchronizer flop count, legal range 2..8.
REQ-003 Parameter ECW, default 8: error counter width, legal range 1..16.
REQ-004 wclk  input  1  destination-domain clock; one clock, every flop on its rising edge.
REQ-005 wrst  input  1  reset, synchronous and active-high.
REQ-006 rptr  input  ASIZE+1  Gray-coded pointer from the foreign domain, asynchronous to wclk.
REQ-007 wq_rptr  output  ASIZE+1  synchronized Gray pointer (last stage).
REQ-008 wq_rptr_bin  output  ASIZE+1  registered binary equivalent of wq_rptr.
REQ-009 wq_rptr_upd  output  1  one-cycle pulse when wq_rptr_bin changes value.
REQ-010 wq_rptr_delta  output  ASIZE+1  registered increment of wq_rptr_bin since previous cycle.
REQ-011 err_pulse  output  1  one-cycle pulse on a Gray-code violation.
REQ-012 err_sticky  output  1  set on any violation, held until reset.
REQ-013 err_cnt  output  ECW  saturating violation count.

Function
REQ-014 rptr SHALL pass through a chain of STAGES flops with no logic between them; wq_rptr equals rptr delayed by exactly STAGES cycles.
REQ-015 wq_rptr_bin SHALL equal the Gray-to-binary conversion of wq_rptr (bin[ASIZE]=g[ASIZE], bin[i]=bin[i+1]^g[i]), registered: latency STAGES+1 from rptr.
REQ-016 A previous-value register SHALL hold last cycle's wq_rptr_bin; wq_rptr_delta SHALL be (wq_rptr_bin - previous) modulo 2^(ASIZE+1), registered with wq_rptr_bin, so wrap 31->0 at ASIZE=4 yields delta 1.
REQ-017 wq_rptr_upd SHALL be high for exactly the cycle in which the new wq_rptr_bin differs from the previous value, and low when unchanged.
REQ-018 An arm counter SHALL count from 0 to STAGES+1 after reset release and stop; checker is armed only when the count has reached STAGES+1.
REQ-019 Checker, when armed: if the Hamming distance between consecutive wq_rptr values exceeds 1, err_pulse SHALL assert the following cycle (latency STAGES+1 from rptr), aligned with wq_rptr_bin.
REQ-020 On each err_pulse err_cnt SHALL increment by 1, saturating at 2^ECW-1 with no wrap; err_sticky SHALL set the same cycle.
REQ-021 Consecutive violations SHALL each produce a pulse and an increment; err_pulse is never stretched.
REQ-022 Unarmed cycles SHALL never produce err_pulse, err_sticky or counter changes; delta and upd operate regardless of arming.

Reset
REQ-023 While wrst is high at a wclk edge, all synchronizer stages, wq_rptr, wq_rptr_bin, previous register, wq_rptr_delta, wq_rptr_upd, err_pulse, err_sticky, err_cnt and arm counter SHALL be 0.
REQ-024 Reset asserted mid-operation SHALL clear all state on the next edge, discarding in-flight samples; rptr is sampled into stage 1 on the first edge with wrst low.
REQ-025 First post-reset transition from 0 to an arbitrary pointer SHALL produce upd and delta normally but no error (checker unarmed).

Configuration
REQ-026 Macro SYNC_PTR_GRAY_CHECK_EN defined: arm counter, Hamming checker, err_pulse, err_sticky and err_cnt SHALL be implemented per REQ-018..022.
REQ-027 Macro undefined: no checker logic SHALL be synthesized; err_pulse, err_sticky, err_cnt SHALL be tied 0; all other behaviour identical.

Verification (ASIZE=4, STAGES=2 unless noted; macro defined unless noted)
REQ-028 wrst high 3 cycles, rptr=5'h1F -> all outputs 0; release -> wq_rptr=5'h1F 2 cycles later, wq_rptr_bin=5'h15, delta=5'h15, upd=1 one cycle later, err_pulse=0.
REQ-029 Armed, rptr steps Gray 0..31 and wraps, one per cycle -> wq_rptr_bin follows at latency 3, delta=1 and upd=1 every cycle including 31->0, err_cnt stays 0.
REQ-030 rptr held at 5'h0C for 10 cycles -> upd=0 and delta=0 after the value settles.
REQ-031 Armed, rptr 5'h00 -> 5'h03 -> err_pulse high exactly 1 cycle at latency 3, err_cnt=1, err_sticky=1 until wrst.
REQ-032 ECW=2, five single-cycle violations -> err_cnt reads 1,2,3,3,3; err_sticky=1.
REQ-033 Macro undefined, stimulus of REQ-031 -> err_pulse, err_sticky, err_cnt remain 0; wq_rptr_bin, delta, upd as with macro.
